// File: rtl/lsu_copy_engine.sv
// Memory-to-memory copy initiator mastering the lsu request port.
// Copies len bytes from src to dst, one byte/half/word unit at a time.
module lsu_copy_engine #(
    parameter int LD_LATENCY = 1,
    parameter int LEN_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [31:0]      i_src,
    input  logic [31:0]      i_dst,
    input  logic [LEN_W-1:0] i_len,
    input  logic [1:0]       i_unit,
    output logic [31:0]      o_lsu_addr,
    output logic [31:0]      o_st_data,
    output logic [1:0]       o_lsu_size,
    output logic             o_lsu_signed,
    output logic             o_lsu_wren,
    input  logic [31:0]      i_ld_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [LEN_W-1:0] o_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [7:0] LAT = 8'(LD_LATENCY);

    state_t           state, state_nx;
    logic [31:0]      src_ptr, dst_ptr, data_q;
    logic [LEN_W-1:0] rem, cnt;
    logic [1:0]       unit_q;
    logic             err_q;
    logic [7:0]       lat_cnt;

    logic [31:0]      step32;
    logic [LEN_W-1:0] step_len;
    logic [31:0]      ld_mask;
    logic             bad;
    logic             last_rd;

    assign last_rd      = (lat_cnt == LAT);
    assign o_lsu_size   = unit_q;
    assign o_lsu_signed = 1'b0;
    assign o_err        = err_q;
    assign o_count      = cnt;

    // Unit size decode: step, load mask and alignment/legality check
    always_comb begin
        step32   = 32'd0;
        step_len = '0;
        ld_mask  = 32'h0;
        bad      = 1'b1;
        case (unit_q)
            2'b00: begin
                step32   = 32'd1;
                step_len = LEN_W'(1);
                ld_mask  = 32'h0000_00ff;
                bad      = 1'b0;
            end
            2'b01: begin
                step32   = 32'd2;
                step_len = LEN_W'(2);
                ld_mask  = 32'h0000_ffff;
                bad      = src_ptr[0] | dst_ptr[0] | rem[0];
            end
            2'b10: begin
                step32   = 32'd4;
                step_len = LEN_W'(4);
                ld_mask  = 32'hffff_ffff;
                bad      = (|src_ptr[1:0]) | (|dst_ptr[1:0]) | (|rem[1:0]);
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nx;
    end

    // Next-state logic; abort wins over everything but reset
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (i_start) state_nx = S_CHK;
            S_CHK: begin
                if (i_abort || bad || rem == '0) state_nx = S_DONE;
                else                             state_nx = S_RD;
            end
            S_RD: begin
                if (i_abort)      state_nx = S_DONE;
                else if (last_rd) state_nx = S_WR;
            end
            S_WR: begin
                if (i_abort || rem == step_len) state_nx = S_DONE;
                else                            state_nx = S_RD;
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        o_lsu_addr = 32'h0;
        o_st_data  = 32'h0;
        o_lsu_wren = 1'b0;
        o_busy     = 1'b1;
        o_done     = 1'b0;
        case (state)
            S_IDLE: o_busy = 1'b0;
            S_RD:   o_lsu_addr = src_ptr;
            S_WR: begin
                o_lsu_addr = dst_ptr;
                o_st_data  = data_q;
                o_lsu_wren = 1'b1;
            end
            S_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand latch, pointers, load capture, count and error
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            src_ptr <= 32'h0;
            dst_ptr <= 32'h0;
            data_q  <= 32'h0;
            rem     <= '0;
            cnt     <= '0;
            unit_q  <= 2'b00;
            err_q   <= 1'b0;
            lat_cnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        src_ptr <= i_src;
                        dst_ptr <= i_dst;
                        rem     <= i_len;
                        unit_q  <= i_unit;
                        err_q   <= 1'b0;
                        cnt     <= '0;
                    end
                end
                S_CHK: begin
                    lat_cnt <= 8'd0;
                    if (i_abort || bad) err_q <= 1'b1;
                end
                S_RD: begin
                    if (i_abort) err_q <= 1'b1;
                    lat_cnt <= lat_cnt + 8'd1;
                    if (last_rd) data_q <= i_ld_data & ld_mask;
                end
                S_WR: begin
                    if (i_abort) err_q <= 1'b1;
                    src_ptr <= src_ptr + step32;
                    dst_ptr <= dst_ptr + step32;
                    rem     <= rem - step_len;
                    cnt     <= cnt + LEN_W'(1);
                    lat_cnt <= 8'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_copy_engine.sv
// Self-checking bench for lsu_copy_engine.
// Byte-level memory model plus a byte-copy reference model.
module tb_lsu_copy_engine;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [31:0] src, dst;
    logic [15:0] len;
    logic [1:0]  unit;
    logic [31:0] lsu_addr, st_data, ld_data;
    logic [1:0]  lsu_size;
    logic        lsu_signed, lsu_wren;
    logic        busy, done, err;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
    } wr_t;

    wr_t        exp_q[$];
    bit [7:0]   mem[bit [31:0]];
    bit [7:0]   rm[bit [31:0]];

    always #5 clk = ~clk;

    lsu_copy_engine #(.LD_LATENCY(LAT), .LEN_W(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
        .i_src(src), .i_dst(dst), .i_len(len), .i_unit(unit),
        .o_lsu_addr(lsu_addr), .o_st_data(st_data),
        .o_lsu_size(lsu_size), .o_lsu_signed(lsu_signed),
        .o_lsu_wren(lsu_wren), .i_ld_data(ld_data),
        .o_busy(busy), .o_done(done), .o_err(err), .o_count(count)
    );

    function automatic bit [7:0] rd_mem(bit [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic bit [7:0] rd_rm(bit [31:0] a);
        return rm.exists(a) ? rm[a] : 8'h00;
    endfunction

    // lsu-side memory: little-endian, stores of 1<<size bytes, registered read
    always @(posedge clk) begin
        if (lsu_wren)
            for (int b = 0; b < 4 && b < (1 << lsu_size); b++)
                mem[lsu_addr + 32'(b)] = st_data[8*b +: 8];
        ld_data <= {rd_mem(lsu_addr + 32'd3), rd_mem(lsu_addr + 32'd2),
                    rd_mem(lsu_addr + 32'd1), rd_mem(lsu_addr)};
    end

    task automatic poke(input bit [31:0] a, input bit [7:0] v);
        mem[a] = v;
        rm[a]  = v;
    endtask

    // Reference: ascending byte copy, one expected store per unit
    task automatic build_expect(input bit [31:0] s, input bit [31:0] d,
                                input bit [1:0] u, input int nunits);
        int   ub;
        wr_t  e;
        ub = 1 << u;
        for (int k = 0; k < nunits; k++) begin
            e.a = d + 32'(k * ub);
            e.d = 32'h0;
            e.s = u;
            for (int b = 0; b < ub; b++) begin
                rm[e.a + 32'(b)] = rd_rm(s + 32'(k * ub + b));
                e.d[8*b +: 8]    = rm[e.a + 32'(b)];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (lsu_wren) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL wr_extra: got store addr=%h data=%h, expected none",
                       lsu_addr, st_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                assert ({lsu_addr, st_data, lsu_size, lsu_signed} ===
                        {e.a, e.d, e.s, 1'b0}) else begin
                    errors++;
                    $error("FAIL wr: got a=%h d=%h sz=%0d sg=%0b, expected a=%h d=%h sz=%0d sg=0",
                           lsu_addr, st_data, lsu_size, lsu_signed, e.a, e.d, e.s);
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic run_copy(input bit [31:0] s, input bit [31:0] d,
                            input bit [15:0] l, input bit [1:0] u,
                            input int probe_c, input bit [31:0] probe_a);
        int ub, n, exp_c, done_c, c;
        bit legal;
        ub    = 1 << u;
        legal = (u != 2'b11) && (s % ub == 0) && (d % ub == 0) && (l % ub == 0);
        n     = legal ? int'(l) / ub : 0;
        exp_c = (n > 0) ? 2 + n * (LAT + 2) : 2;
        if (legal) build_expect(s, d, u, n);
        tick();
        src = s; dst = d; len = l; unit = u; start = 1'b1;
        done_c = 0;
        c = 0;
        while (done_c == 0 && c < exp_c + 10) begin
            tick();
            c++;
            if (c == 1) start = 1'b0;
            if (c == probe_c) chk("probe_addr", 64'(lsu_addr), 64'(probe_a));
            if (done === 1'b1) done_c = c;
        end
        chk("done_cycle", 64'(done_c), 64'(exp_c));
        chk("err", 64'(err), 64'(!legal));
        chk("count", 64'(count), 64'(n));
        tick();
        chk("idle_after", 64'({busy, done}), 64'(0));
        chk("stores_left", 64'(exp_q.size()), 64'(0));
    endtask

    // Word copy of len 40 interrupted during the third read
    task automatic run_interrupt(input bit use_reset);
        int extra_done;
        build_expect(32'h0, 32'h300, 2'b10, 2);
        tick();
        src = 32'h0; dst = 32'h300; len = 16'd40; unit = 2'b10; start = 1'b1;
        extra_done = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c == 8) begin
                if (use_reset) rst = 1'b1;
                else           abort = 1'b1;
            end
            if (c == 9) begin
                if (use_reset) begin
                    chk("rst_outs", 64'({lsu_addr, st_data} | 64'({lsu_size, lsu_wren, busy, done, err, count})),
                        64'(0));
                    rst = 1'b0;
                end else begin
                    chk("abort_done", 64'({done, err}), 64'(2'b11));
                    chk("abort_count", 64'(count), 64'(2));
                    abort = 1'b0;
                end
            end
            if (c >= 10 && done === 1'b1) extra_done++;
        end
        chk(use_reset ? "rst_no_done" : "abort_no_done", 64'(extra_done), 64'(0));
        chk("int_stores_left", 64'(exp_q.size()), 64'(0));
        chk("int_count_hold", 64'(count), use_reset ? 64'(0) : 64'(2));
    endtask

    initial begin
        int d1, d2, dones, ub;
        bit [1:0]  u;
        bit [31:0] s, d;
        bit [15:0] l;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        src = '0; dst = '0; len = '0; unit = '0;
        repeat (3) tick();
        chk("reset_outs", 64'({lsu_addr, st_data} | 64'({lsu_size, lsu_wren, busy, done, err, count})),
            64'(0));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) poke(32'(i), 8'(8'h11 * (i / 4 + 1)));
        run_copy(32'h0, 32'h100, 16'd16, 2'b10, 0, 32'h0);

        poke(32'h3c, 8'ha5); poke(32'h3d, 8'h5a); poke(32'h3e, 8'hff);
        run_copy(32'h3c, 32'h1000_0000, 16'd3, 2'b00, 0, 32'h0);

        run_copy(32'h29, 32'h200, 16'd4, 2'b01, 0, 32'h0);
        run_copy(32'h28, 32'h200, 16'd4, 2'b11, 0, 32'h0);
        run_copy(32'h0, 32'h200, 16'd0, 2'b10, 0, 32'h0);

        run_interrupt(1'b0);
        run_interrupt(1'b1);

        build_expect(32'h0, 32'h380, 2'b10, 2);
        build_expect(32'h0, 32'h380, 2'b10, 2);
        tick();
        src = 32'h0; dst = 32'h380; len = 16'd8; unit = 2'b10; start = 1'b1;
        d1 = 0; d2 = 0; dones = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 9) chk("hold_idle_gap", 64'(busy), 64'(0));
            if (c == 10) start = 1'b0;
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) d1 = c;
                else            d2 = c;
            end
        end
        chk("hold_dones", 64'(dones), 64'(2));
        chk("hold_d1", 64'(d1), 64'(8));
        chk("hold_d2", 64'(d2), 64'(17));
        chk("hold_stores_left", 64'(exp_q.size()), 64'(0));

        for (int i = 0; i < 4; i++) poke(32'hffff_fffc + 32'(i), 8'(8'hc0 + i));
        run_copy(32'hffff_fffc, 32'h200, 16'd8, 2'b10, 5, 32'h0000_0000);

        for (int i = 0; i < 768; i++) poke(32'h400 + 32'(i), 8'($urandom));
        for (int t = 0; t < 24; t++) begin
            u  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ub = (u == 2'b11) ? 4 : (1 << u);
            s  = 32'h400 + (32'($urandom_range(0, 255)) & ~32'(ub - 1));
            d  = 32'h400 + (32'($urandom_range(0, 255)) & ~32'(ub - 1));
            l  = 16'($urandom_range(0, 8) * ub);
            if ($urandom_range(0, 7) == 0) s = s + 32'd1;
            if ($urandom_range(0, 7) == 0) l = l + 16'd1;
            run_copy(s, d, l, u, 0, 32'h0);
        end

        foreach (rm[a]) chk("mem_final", 64'(rd_mem(a)), 64'(rm[a]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_copy_engine.md
Name: lsu_copy_engine

Overview:
- Memory-to-memory copy initiator that drives the lsu request interface as its master.
- Reads a block from source addresses and writes it to destination addresses, one transfer unit (byte, half-word or word) at a time.
- Sits beside the core as a second requester. The lsu request mux and arbitration sit outside this block.
- Typical use: filling the io window at 0x1000_xxxx, e.g. LEDs, HEX or LCD, from a table held in data memory.

Parameters:
- LD_LATENCY, 1: clock edges between address presentation and a valid i_ld_data (0 = combinational read).
- LEN_W, 16: width of the byte-length operand.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  start request; sampled only in IDLE.
- i_abort  input  1  terminate the current copy.
- i_src  input  32  source byte address.
- i_dst  input  32  destination byte address.
- i_len  input  LEN_W  length in bytes.
- i_unit  input  2  transfer size: 00 byte, 01 half-word, 10 word; 11 is illegal.
- o_lsu_addr  output  32  address to lsu.
- o_st_data  output  32  store data to lsu.
- o_lsu_size  output  2  size to lsu; equals the latched unit.
- o_lsu_signed  output  1  always 0 (unsigned loads, zero-extended).
- o_lsu_wren  output  1  store strobe.
- i_ld_data  input  32  load data from lsu.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle completion pulse.
- o_err  output  1  sticky error flag.
- o_count  output  LEN_W  number of units completed in the current or last copy.

Behaviour:

Reset:
- i_reset=1 forces IDLE.
- o_lsu_addr, o_st_data, o_lsu_size, o_lsu_wren, o_busy, o_done, o_err and o_count all go to 0.
- Reset takes effect mid-copy too; no further lsu access is issued after the reset edge.

Start and validation:
- In IDLE with i_start=1, the block latches src, dst, len and unit, clears o_err and o_count, and goes to CHK.
- When o_busy=1, i_start is ignored.
- Unit byte size U = 1, 2 or 4.
- In CHK, the copy is rejected when any of these hold:
  - i_unit=11;
  - src mod U ≠ 0;
  - dst mod U ≠ 0;
  - len mod U ≠ 0.
- On rejection: o_err=1, go to DONE, no lsu access.
- If len=0 (and no error): go to DONE, o_err=0, no access.
- Otherwise go to RD.

States:
- IDLE
  - o_lsu_wren=0, o_lsu_addr=0, o_st_data=0.
- RD
  - o_lsu_addr=src_ptr, o_lsu_wren=0, held for LD_LATENCY+1 cycles.
  - i_ld_data is captured into the data register on the last of those cycles, masked to U bytes.
  - Then go to WR.
- WR
  - Exactly one cycle: o_lsu_addr=dst_ptr, o_st_data=captured data, o_lsu_wren=1.
  - On exit: src_ptr+=U, dst_ptr+=U, remaining-=U, o_count+=1.
  - If remaining=0 go to DONE, else go to RD.
- DONE
  - One cycle: o_done=1, o_busy=1, o_lsu_wren=0.
  - Then go to IDLE.

Timing:
- Cycles per unit = LD_LATENCY+2 (3 at default).
- Total from the start edge to the o_done pulse = 1 (CHK) + N·(LD_LATENCY+2), with the pulse in the following cycle.

Arithmetic and ordering:
- Pointers wrap modulo 2^32.
- Copy is strictly ascending. Overlapping regions with dst>src propagate already-copied data; this is defined behaviour, not an error.

Abort:
- i_abort=1 in CHK, RD or WR: the next state is DONE, with o_err=1.
- A WR cycle that is active on the abort edge has already been issued and counts in o_count.
- i_abort in IDLE or DONE has no effect.

Simultaneous events:
- i_reset beats i_abort, which beats i_start.
- i_start together with the o_done cycle is ignored; the block accepts it only in IDLE.

Other output rules:
- o_err holds until the next accepted start or reset.
- o_count holds after DONE.

Test Plan:
1. Word copy: src=0x0, dst=0x100, len=16, unit=10, memory preloaded 0x11111111..0x44444444.
   - Expect 4 wren pulses at 0x100/104/108/10C with matching data.
   - o_done 14 cycles after the start edge; o_count=4, o_err=0.
2. Byte copy into the io window: src=0x3C, dst=0x1000_0000, len=3, unit=00, source bytes 0xA5,0x5A,0xFF.
   - Expect 3 wren pulses, size=00, o_st_data=0x000000A5/0x0000005A/0x000000FF.
   - o_lsu_signed stays 0 throughout.
3. Misaligned half-word copy: src=0x29, unit=01, len=4.
   - No wren at any time; o_err=1; o_done pulses 2 cycles after start.
   - Same outcome with unit=11.
4. Zero length: len=0, unit=10.
   - o_done pulses, o_err=0, o_count=0, no lsu access.
5. Abort and reset: word copy with len=40, i_abort asserted during the 3rd RD.
   - o_count=2, o_err=1, no further wren.
   - Repeat with i_reset instead of i_abort: all outputs are 0 next cycle and o_done never pulses.
6. Restart and wrap:
   - i_start held high through a whole copy: exactly one copy runs; a second copy is accepted only once the block has returned to IDLE.
   - src=0xFFFF_FFFC, len=8, unit=10: the second read address is 0x0000_0000.
